// File: rtl/mips_dmem_io.sv
// -----------------------------------------------------------------------------
// mips_dmem_io
//
// Data-memory / I/O block for a single-cycle MIPS core. Behind the core's
// load/store port it combines:
//   * a 64-word RAM (0x000-0x0FC, word indexed by dataadr[7:2])
//   * TXDATA (0x100): stores push writedata[7:0] into a transmit FIFO
//   * STATUS (0x104): {overflow, count, empty, full}; a store with
//     writedata[8]=1 clears the sticky overflow flag
//   * TIMER  (0x108): optional free-running 32-bit counter
// Only dataadr[11:2] is decoded, so the map aliases every 4 KiB and byte
// offsets within a word are ignored. Loads are combinational from dataadr.
//
// Optional feature: define MIPS_DMEM_TIMER_EN to build the timer. Without
// it, 0x108 reads as zero and stores to it are ignored.
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   reset      synchronous, active-high; clears FIFO, STATUS, timer (not RAM)
//   memwrite   core store strobe
//   dataadr    core byte address
//   writedata  core store data
//   readdata   load data, combinational from dataadr
//   tx_valid   FIFO not empty
//   tx_data    FIFO head byte (don't care while tx_valid is low)
//   tx_ready   sink accepts the head byte when tx_valid & tx_ready
//
// Parameter
//   FIFO_DEPTH TX FIFO entries, power of two in 2..32
// -----------------------------------------------------------------------------
module mips_dmem_io #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int         PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [5:0] DEPTH_CNT  = 6'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Word offsets (dataadr[11:2]) of the I/O registers.
  localparam logic [9:0] WORD_TXDATA = 10'h040;
  localparam logic [9:0] WORD_STATUS = 10'h041;
  localparam logic [9:0] WORD_TIMER  = 10'h042;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [9:0] word_adr;
  logic       sel_ram;
  logic       sel_txdata;
  logic       sel_status;
  logic       sel_timer;

  assign word_adr   = dataadr[11:2];
  assign sel_ram    = (word_adr[9:6] == 4'h0);
  assign sel_txdata = (word_adr == WORD_TXDATA);
  assign sel_status = (word_adr == WORD_STATUS);
  assign sel_timer  = (word_adr == WORD_TIMER);

  // Upper address bits and byte offset are deliberately not decoded.
  logic unused_adr_bits;
  assign unused_adr_bits = &{1'b0, dataadr[31:12], dataadr[1:0]};

  // ---------------------------------------------------------------------------
  // RAM: no reset, and stores land even while reset is asserted. Read is
  // asynchronous because the single-cycle core needs load data in the same
  // cycle it presents the address.
  // ---------------------------------------------------------------------------
  logic [31:0] ram_mem [0:63];

  always_ff @(posedge clk) begin
    if (memwrite && sel_ram) begin
      ram_mem[word_adr[5:0]] <= writedata;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [5:0]       count_reg, count_next;
  logic             overflow_reg, overflow_next;

  logic fifo_full;
  logic fifo_empty;
  logic push_req;
  logic push;
  logic pop;
  logic overflow_set;
  logic overflow_clr;

  assign fifo_full  = (count_reg == DEPTH_CNT);
  assign fifo_empty = (count_reg == 6'd0);

  // tx_ready is meaningless while empty, so a pop needs a byte present.
  assign pop      = !fifo_empty && tx_ready;
  assign push_req = memwrite && sel_txdata && !reset;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = push_req && (!fifo_full || pop);

  assign overflow_set = push_req && fifo_full && !pop;
  assign overflow_clr = memwrite && sel_status && writedata[8];

  // Per-entry write enables, so each slot only captures on its own pointer.
  logic [FIFO_DEPTH-1:0] entry_we;

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_we[i]) begin
        fifo_mem[i] <= writedata[7:0];
      end
    end
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    // Pointers are PTR_W bits wide, so the increment wraps modulo FIFO_DEPTH.
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + 6'd1;
      2'b01:   count_next = count_reg - 6'd1;
      default: count_next = count_reg;
    endcase

    // A fresh overflow on the same edge as a clear wins, so the event
    // is never silently lost.
    if (overflow_set) begin
      overflow_next = 1'b1;
    end else if (overflow_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Head comes straight from storage; it only moves on a pop, so it holds
  // steady while the sink stalls.
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_mem[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
  logic [31:0] timer_val;

`ifdef MIPS_DMEM_TIMER_EN
  logic [31:0] timer_reg, timer_next;

  // A store replaces the increment for that edge; counting resumes after.
  always_comb begin
    timer_next = timer_reg + 32'd1;
    if (memwrite && sel_timer) begin
      timer_next = writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_next;
    end
  end

  assign timer_val = timer_reg;
`else
  assign timer_val = 32'd0;
`endif

  // ---------------------------------------------------------------------------
  // Load data
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;

  assign status_word = {23'd0, overflow_reg, count_reg, fifo_empty, fifo_full};

  always_comb begin
    readdata = 32'd0;
    if (sel_ram) begin
      readdata = ram_mem[word_adr[5:0]];
    end else if (sel_status) begin
      readdata = status_word;
    end else if (sel_timer) begin
      readdata = timer_val;
    end
    // TXDATA and unmapped offsets read as zero.
  end

endmodule

// File: tb/tb_mips_dmem_io.sv
// -----------------------------------------------------------------------------
// tb_mips_dmem_io
//
// Directed bench for mips_dmem_io. The stimulus process pushes expected load
// values / tx_valid levels and expected TX bytes into queues; a monitor on
// the falling edge pops and compares whenever a load check is flagged or a
// byte transfer (tx_valid & tx_ready) is about to happen.
// -----------------------------------------------------------------------------
module tb_mips_dmem_io;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  always #5 clk = ~clk;

  mips_dmem_io #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  typedef struct {
    bit          kind;   // 0: readdata, 1: tx_valid
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t       chk_q[$];
  logic [7:0] tx_exp[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         tx_count   = 0;
  bit         load_chk   = 1'b0;

`ifdef MIPS_DMEM_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (load_chk) begin
      chk_t        c;
      logic [31:0] act;
      if (chk_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL chk_underflow: got check strobe, required a queued expectation");
      end else begin
        c   = chk_q.pop_front();
        act = c.kind ? {31'd0, tx_valid} : readdata;
        compared++;
        if (act !== c.exp) begin
          mismatched++;
          $display("FAIL %s: got %08h required %08h", c.name, act, c.exp);
        end else begin
          $display("check %s: %08h", c.name, act);
        end
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      logic [7:0] e;
      tx_count++;
      compared++;
      if (tx_exp.size() == 0) begin
        mismatched++;
        $display("FAIL tx_unexpected: got byte %02h required no transfer", tx_data);
      end else begin
        e = tx_exp.pop_front();
        if (tx_data !== e) begin
          mismatched++;
          $display("FAIL tx_byte: got %02h required %02h", tx_data, e);
        end else begin
          $display("tx byte %02h", tx_data);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit accepted);
    if (accepted) tx_exp.push_back(b);
    store(32'h100, {24'd0, b});
  endtask

  task automatic expect_load(input logic [31:0] a, input logic [31:0] e, input string n);
    chk_t c;
    dataadr = a;
    c.kind  = 1'b0;
    c.exp   = e;
    c.name  = n;
    chk_q.push_back(c);
    load_chk = 1'b1;
    tick();
    load_chk = 1'b0;
  endtask

  task automatic expect_txv(input logic e, input string n);
    chk_t c;
    c.kind = 1'b1;
    c.exp  = {31'd0, e};
    c.name = n;
    chk_q.push_back(c);
    load_chk = 1'b1;
    tick();
    load_chk = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    memwrite  = 1'b0;
    dataadr   = 32'd0;
    writedata = 32'd0;
    tx_ready  = 1'b0;

    tick();
    tick();
    // Still in reset: everything cleared.
    expect_load(32'h104, 32'h002, "rst_status");
    expect_txv(1'b0, "rst_txvalid");
    expect_load(32'h108, 32'h0, "rst_timer");
    reset = 1'b0;

    // RAM and aliasing.
    store(32'h04C, 32'hDEADBEEF);
    store(32'h000, 32'h12345678);
    expect_load(32'h04C, 32'hDEADBEEF, "ram_04c");
    expect_load(32'h104C, 32'hDEADBEEF, "ram_alias_104c");
    expect_load(32'h04E, 32'hDEADBEEF, "ram_byteoff");
    expect_load(32'h000, 32'h12345678, "ram_000");
    store(32'h10C, 32'hFFFFFFFF);
    expect_load(32'h10C, 32'h0, "unmapped_10c");
    expect_load(32'h100, 32'h0, "txdata_load");

    // Timer load and wrap.
    store(32'h108, 32'hFFFFFFFE);
    expect_load(32'h108, TIMER_EN ? 32'hFFFFFFFE : 32'h0, "timer_0");
    expect_load(32'h108, TIMER_EN ? 32'hFFFFFFFF : 32'h0, "timer_1");
    expect_load(32'h108, 32'h0, "timer_wrap");

    // Fill past full with the sink stalled: fifth byte dropped.
    tx_ready = 1'b0;
    send(8'h41, 1'b1);
    expect_txv(1'b1, "push_visible");
    send(8'h42, 1'b1);
    send(8'h43, 1'b1);
    send(8'h44, 1'b1);
    send(8'h45, 1'b0);
    expect_load(32'h104, 32'h111, "status_overflow");
    tx_ready = 1'b1;
    repeat (4) tick();
    expect_txv(1'b0, "drain_txvalid");
    expect_load(32'h104, 32'h102, "status_drained");

    // Overflow clear only with bit 8 set.
    store(32'h104, 32'h000);
    expect_load(32'h104, 32'h102, "ovf_keep");
    store(32'h104, 32'h100);
    expect_load(32'h104, 32'h002, "ovf_clear");

    // Push while full with a simultaneous pop.
    tx_ready = 1'b0;
    send(8'h61, 1'b1);
    send(8'h62, 1'b1);
    send(8'h63, 1'b1);
    send(8'h64, 1'b1);
    expect_load(32'h104, 32'h011, "status_full");
    tx_exp.push_back(8'h55);
    memwrite  = 1'b1;
    dataadr   = 32'h100;
    writedata = 32'h55;
    tx_ready  = 1'b1;
    tick();
    memwrite  = 1'b0;
    tx_ready  = 1'b0;
    expect_load(32'h104, 32'h011, "full_pushpop");
    tx_ready = 1'b1;
    repeat (4) tick();
    expect_txv(1'b0, "drain2_txvalid");

    // Push and pop together when partially full.
    tx_ready = 1'b0;
    send(8'h71, 1'b1);
    send(8'h72, 1'b1);
    tx_exp.push_back(8'h73);
    memwrite  = 1'b1;
    dataadr   = 32'h100;
    writedata = 32'h73;
    tx_ready  = 1'b1;
    tick();
    memwrite  = 1'b0;
    tx_ready  = 1'b0;
    expect_load(32'h104, 32'h008, "mid_pushpop");
    send(8'h74, 1'b1);
    expect_load(32'h104, 32'h00C, "three_queued");

    // Reset mid-operation; FIFO push during reset ignored, RAM store kept.
    tx_exp.delete();
    reset     = 1'b1;
    memwrite  = 1'b1;
    dataadr   = 32'h100;
    writedata = 32'h99;
    tick();
    dataadr   = 32'h050;
    writedata = 32'hCAFEF00D;
    tick();
    memwrite  = 1'b0;
    reset     = 1'b0;
    expect_load(32'h108, 32'h0, "reset_timer");
    expect_txv(1'b0, "reset_txvalid");
    expect_load(32'h104, 32'h002, "reset_status");
    expect_load(32'h04C, 32'hDEADBEEF, "reset_ram_kept");
    expect_load(32'h050, 32'hCAFEF00D, "reset_ram_store");

    // tx_ready while empty must not produce a transfer.
    tx_ready = 1'b1;
    repeat (3) tick();
    tx_ready = 1'b0;
    tick();

    compared++;
    if (tx_count != 10) begin
      mismatched++;
      $display("FAIL tx_total: got %0d transfers required %0d", tx_count, 10);
    end else begin
      $display("check tx_total: %0d", tx_count);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_dmem_io.md
MIPS_DMEM_IO -- requirements
Module: mips_dmem_io

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: memwrite  input  1  core store strobe, sampled at rising edge.
REQ-005 SHALL have port: dataadr  input  32  core byte address (core ALU result).
REQ-006 SHALL have port: writedata  input  32  core store data.
REQ-007 SHALL have port: readdata  output  32  load data to core, combinational from dataadr.
REQ-008 SHALL have port: tx_valid  output  1  TX byte available.
REQ-009 SHALL have port: tx_data  output  8  TX byte, FIFO head.
REQ-010 SHALL have port: tx_ready  input  1  sink accepts byte; transfer when tx_valid & tx_ready at rising edge.

Function
REQ-011 SHALL decode dataadr[11:2] only; dataadr[31:12] and dataadr[1:0] ignored (aliasing accepted).
REQ-012 SHALL map 0x000-0x0FC to 64-word RAM indexed by dataadr[7:2]; store writes full word at edge; load returns word combinationally.
REQ-013 SHALL map 0x100 TXDATA: store pushes writedata[7:0] into FIFO; load returns 0.
REQ-014 SHALL map 0x104 STATUS load: bit0 full, bit1 empty, bits[7:2] occupancy count, bit8 sticky overflow, others 0.
REQ-015 SHALL clear overflow on store to 0x104 with writedata[8]=1; other STATUS store bits ignored.
REQ-016 SHALL map 0x108 TIMER (see Configuration); all other offsets load 0, stores ignored.
REQ-017 SHALL present FIFO head on tx_data with tx_valid = not empty; tx_data SHALL be stable while tx_valid & !tx_ready.
REQ-018 SHALL make a pushed byte visible on tx_valid the cycle after the push edge (no same-cycle bypass).
REQ-019 SHALL, on push when full and no pop that edge, drop the byte, leave FIFO unchanged, set overflow.
REQ-020 SHALL, on simultaneous push and pop when full, accept both; count stays FIFO_DEPTH, no overflow.
REQ-021 SHALL, on simultaneous push and pop when not full/not empty, keep count unchanged.
REQ-022 SHALL wrap read/write pointers modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-023 SHALL ignore tx_ready while empty (no pop, no pointer movement).

Reset
REQ-024 SHALL, while reset high at edge: empty FIFO, pointers and count 0, overflow 0, timer 0, tx_valid 0.
REQ-025 SHALL discard queued FIFO bytes on reset mid-operation; stores coinciding with reset ignored for FIFO/STATUS/TIMER.
REQ-026 SHALL NOT reset RAM contents; RAM stores during reset still take effect.
REQ-027 SHALL keep tx_data value undefined-but-don't-care while tx_valid=0.

Configuration
REQ-028 SHALL use macro MIPS_DMEM_TIMER_EN.
REQ-029 With MIPS_DMEM_TIMER_EN defined: 32-bit timer increments every cycle, wraps 0xFFFFFFFF->0; load 0x108 returns current value; store 0x108 loads writedata (load wins over increment), increments from next cycle.
REQ-030 Without MIPS_DMEM_TIMER_EN: no timer register; 0x108 loads 0, stores ignored.

Verification
REQ-031 Store 0xDEADBEEF to 0x04C, then load 0x04C and 0x104C -> readdata 0xDEADBEEF both (aliasing).
REQ-032 tx_ready=0; store bytes 0x41,0x42,0x43,0x44,0x45 to 0x100 -> STATUS after: full=1, count=4, overflow=1; tx_ready=1 drains 0x41..0x44 in order, then tx_valid=0, STATUS empty=1.
REQ-033 FIFO full, tx_ready=1, store 0x55 to 0x100 same edge -> no overflow, count stays 4, 0x55 emerges last.
REQ-034 Store 0x100 to 0x104 after overflow -> STATUS bit8=0; store 0x000 to 0x104 -> bit8 unchanged.
REQ-035 With MIPS_DMEM_TIMER_EN: store 0xFFFFFFFE to 0x108 -> loads read 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on following cycles; without macro 0x108 reads 0.
REQ-036 Queue 3 bytes, assert reset one cycle -> tx_valid=0, STATUS=0x002, timer 0, RAM word at 0x04C retained.
